// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: grant encoding,
// default parameters and the starvation-counter width helper.
package dmem_arb_pkg;

    localparam int DEF_AW         = 16;
    localparam int DEF_DW         = 16;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_HOST = 2'd2
    } gnt_e;

    // Counter must hold 0..max; a zero max still needs one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the host/debug port and the data memory.
// The slave view belongs to the arbiter, the master view to everything around it.
interface dmem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, host_rdata, host_ack,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, host_rdata, host_ack,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_starve_counter.sv
// Saturating count of consecutive CPU wins while the host waits.
// Clear has priority over increment; at_max signals the forced host turn.
module dmem_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);
    localparam int            CW    = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] MAX_V = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != MAX_V)) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_max = (cnt_reg == MAX_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the host port.
// CPU has priority; the host is forced through after STARVE_MAX consecutive CPU wins.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);
    gnt_e          gnt;
    logic          host_eligible;
    logic          at_max;
    logic          host_ack_reg;
    logic [DW-1:0] host_rdata_reg;
    logic [AW-1:0] mem_addr_next;
    logic [DW-1:0] mem_wdata_next;
    logic          mem_we_next;

    // The ack cycle doubles as a cooldown so a still-held request is not serviced twice.
    assign host_eligible = bus.host_req & ~host_ack_reg;

    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (host_eligible && (!bus.cpu_req || at_max)) begin
                gnt = GNT_HOST;
            end else if (bus.cpu_req) begin
                gnt = GNT_CPU;
            end
        end
    end

    always_comb begin
        mem_addr_next  = '0;
        mem_wdata_next = '0;
        mem_we_next    = 1'b0;
        case (gnt)
            GNT_CPU: begin
                mem_addr_next  = bus.cpu_addr;
                mem_wdata_next = bus.cpu_wdata;
                mem_we_next    = bus.cpu_we;
            end
            GNT_HOST: begin
                mem_addr_next  = bus.host_addr;
                mem_wdata_next = bus.host_wdata;
                mem_we_next    = bus.host_we;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_addr   = mem_addr_next;
    assign bus.mem_wdata  = mem_wdata_next;
    assign bus.mem_we     = mem_we_next;
    assign bus.cpu_stall  = bus.cpu_req & (gnt == GNT_HOST);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.host_ack   = host_ack_reg;
    assign bus.host_rdata = host_rdata_reg;

    dmem_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    ((gnt == GNT_HOST) || !host_eligible),
        .inc    ((gnt == GNT_CPU) && host_eligible),
        .at_max (at_max)
    );

    // Read data is captured on the grant edge; for host writes it is simply whatever the memory shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_ack_reg   <= 1'b0;
            host_rdata_reg <= '0;
        end else begin
            host_ack_reg <= (gnt == GNT_HOST);
            if (gnt == GNT_HOST) begin
                host_rdata_reg <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (STARVE_MAX 4 and 0) with their own memories,
// a per-cycle behavioural reference, directed scenarios and randomized traffic.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Drive side, index 0 = STARVE_MAX 4 instance, index 1 = STARVE_MAX 0 instance
    logic        c_req  [2] = '{1'b0, 1'b0};
    logic        c_we   [2] = '{1'b0, 1'b0};
    logic [15:0] c_addr [2] = '{16'h0, 16'h0};
    logic [15:0] c_wd   [2] = '{16'h0, 16'h0};
    logic        h_req  [2] = '{1'b0, 1'b0};
    logic        h_we   [2] = '{1'b0, 1'b0};
    logic [15:0] h_addr [2] = '{16'h0, 16'h0};
    logic [15:0] h_wd   [2] = '{16'h0, 16'h0};

    logic        o_we    [2];
    logic [15:0] o_addr  [2];
    logic [15:0] o_wd    [2];
    logic [15:0] o_crd   [2];
    logic [15:0] o_hrd   [2];
    logic        o_stall [2];
    logic        o_ack   [2];

    dmem_port_arbiter_if #(.AW(16), .DW(16)) bus4 ();
    dmem_port_arbiter_if #(.AW(16), .DW(16)) bus0 ();

    dmem_port_arbiter #(.AW(16), .DW(16), .STARVE_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    dmem_port_arbiter #(.AW(16), .DW(16), .STARVE_MAX(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus4.cpu_req = c_req[0];   assign bus4.cpu_we = c_we[0];
    assign bus4.cpu_addr = c_addr[0]; assign bus4.cpu_wdata = c_wd[0];
    assign bus4.host_req = h_req[0];  assign bus4.host_we = h_we[0];
    assign bus4.host_addr = h_addr[0]; assign bus4.host_wdata = h_wd[0];
    assign bus0.cpu_req = c_req[1];   assign bus0.cpu_we = c_we[1];
    assign bus0.cpu_addr = c_addr[1]; assign bus0.cpu_wdata = c_wd[1];
    assign bus0.host_req = h_req[1];  assign bus0.host_we = h_we[1];
    assign bus0.host_addr = h_addr[1]; assign bus0.host_wdata = h_wd[1];

    assign o_we[0] = bus4.mem_we;  assign o_addr[0] = bus4.mem_addr;  assign o_wd[0] = bus4.mem_wdata;
    assign o_crd[0] = bus4.cpu_rdata; assign o_hrd[0] = bus4.host_rdata;
    assign o_stall[0] = bus4.cpu_stall; assign o_ack[0] = bus4.host_ack;
    assign o_we[1] = bus0.mem_we;  assign o_addr[1] = bus0.mem_addr;  assign o_wd[1] = bus0.mem_wdata;
    assign o_crd[1] = bus0.cpu_rdata; assign o_hrd[1] = bus0.host_rdata;
    assign o_stall[1] = bus0.cpu_stall; assign o_ack[1] = bus0.host_ack;

    // Data memories: synchronous write, combinational read, 256 words aliased on addr[7:0]
    logic [15:0] tmem0 [256];
    logic [15:0] tmem1 [256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) tmem0[i] <= 16'h0;
        end else if (bus4.mem_we) begin
            tmem0[bus4.mem_addr[7:0]] <= bus4.mem_wdata;
        end
    end
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) tmem1[i] <= 16'h0;
        end else if (bus0.mem_we) begin
            tmem1[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
        end
    end
    assign bus4.mem_rdata = tmem0[bus4.mem_addr[7:0]];
    assign bus0.mem_rdata = tmem1[bus0.mem_addr[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    int          smax   [2] = '{4, 0};
    int          m_cnt  [2] = '{0, 0};
    logic        m_ack  [2] = '{1'b0, 1'b0};
    logic [15:0] m_hrd  [2] = '{16'h0, 16'h0};
    int          cnt_nx [2];
    logic        ack_nx [2];
    logic [15:0] hrd_nx [2];
    logic        pw_en  [2] = '{1'b0, 1'b0};
    logic [7:0]  pw_a   [2];
    logic [15:0] pw_d   [2];
    logic [15:0] ref_mem [2][256];

    task automatic model_check(input int k);
        logic        elig;
        int          g;
        logic        ewe;
        logic [15:0] ea;
        logic [15:0] ew;
        elig = h_req[k] && !m_ack[k];
        if (rst) g = 0;
        else if (elig && (!c_req[k] || m_cnt[k] == smax[k])) g = 2;
        else if (c_req[k]) g = 1;
        else g = 0;
        ewe = (g == 1) ? c_we[k]   : (g == 2) ? h_we[k]   : 1'b0;
        ea  = (g == 1) ? c_addr[k] : (g == 2) ? h_addr[k] : 16'h0;
        ew  = (g == 1) ? c_wd[k]   : (g == 2) ? h_wd[k]   : 16'h0;
        chk($sformatf("mem_we[%0d]", k), o_we[k], ewe);
        chk($sformatf("mem_addr[%0d]", k), o_addr[k], ea);
        chk($sformatf("mem_wdata[%0d]", k), o_wd[k], ew);
        chk($sformatf("cpu_stall[%0d]", k), o_stall[k], c_req[k] && g == 2);
        chk($sformatf("host_ack[%0d]", k), o_ack[k], m_ack[k]);
        chk($sformatf("host_rdata[%0d]", k), o_hrd[k], m_hrd[k]);
        if (g == 1) chk($sformatf("cpu_rdata[%0d]", k), o_crd[k], ref_mem[k][c_addr[k][7:0]]);
        if (g == 2 || !elig) cnt_nx[k] = 0;
        else if (g == 1) cnt_nx[k] = (m_cnt[k] < smax[k]) ? m_cnt[k] + 1 : smax[k];
        else cnt_nx[k] = m_cnt[k];
        ack_nx[k] = (g == 2);
        hrd_nx[k] = (g == 2) ? ref_mem[k][h_addr[k][7:0]] : m_hrd[k];
        pw_en[k]  = ewe;
        pw_a[k]   = ea[7:0];
        pw_d[k]   = ew;
    endtask

    always @(negedge clk) begin
        model_check(0);
        model_check(1);
    end

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0;
                m_ack[k] = 1'b0;
                m_hrd[k] = 16'h0;
                if (mem_clr) for (int i = 0; i < 256; i++) ref_mem[k][i] = 16'h0;
            end else begin
                m_cnt[k] = cnt_nx[k];
                m_ack[k] = ack_nx[k];
                m_hrd[k] = hrd_nx[k];
                if (pw_en[k]) ref_mem[k][pw_a[k]] = pw_d[k];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Raise a host request, wait (bounded) for the ack, then release it after the ack cycle.
    task automatic host_op(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        h_req[k] = 1'b1; h_we[k] = we; h_addr[k] = a; h_wd[k] = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_ack[k]) begin
                got = 1'b1;
                lat = i;
            end else begin
                next_cyc();
            end
        end
        chk($sformatf("host_ack_seen[%0d]", k), got, 1'b1);
        rd = o_hrd[k];
        next_cyc();
        h_req[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] rd;
    int          lat;
    logic        seen_stall [2];
    logic        seen_ack   [2];

    initial begin
        // Reset with both requesters active: every output must stay quiet
        c_req[0] = 1'b1; h_req[0] = 1'b1; h_addr[0] = 16'h0011; c_addr[0] = 16'h0022;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", o_stall[0], 1'b0);
        chk("rst_we", o_we[0], 1'b0);
        chk("rst_addr", o_addr[0], 16'h0);
        chk("rst_ack", o_ack[0], 1'b0);
        chk("rst_hrd", o_hrd[0], 16'h0);
        chk("rst_cnt", dut4.u_cnt.cnt_reg, 3'd0);
        c_req[0] = 1'b0; h_req[0] = 1'b0;
        next_cyc();
        rst = 1'b0; mem_clr = 1'b0;
        next_cyc();

        // Reset arriving mid host write: write suppressed, outputs forced low at once
        h_req[0] = 1'b1; h_we[0] = 1'b1; h_addr[0] = 16'h0050; h_wd[0] = 16'hDEAD;
        @(negedge clk);
        chk("mid_we_before", o_we[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_we", o_we[0], 1'b0);
        chk("mid_stall", o_stall[0], 1'b0);
        chk("mid_ack", o_ack[0], 1'b0);
        chk("mid_cnt", dut4.u_cnt.cnt_reg, 3'd0);
        h_req[0] = 1'b0; h_we[0] = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("mid_ack_after", o_ack[0], 1'b0);
        next_cyc();
        rst = 1'b0;
        host_op(0, 1'b0, 16'h0050, 16'h0, rd, lat);
        chk("mid_suppressed", rd, 16'h0000);

        // Host only: write then read back, ack one cycle after each request
        host_op(0, 1'b1, 16'h0010, 16'hBEEF, rd, lat);
        chk("hw_lat", lat, 1);
        host_op(0, 1'b0, 16'h0010, 16'h0, rd, lat);
        chk("hr_lat", lat, 1);
        chk("hr_data", rd, 16'hBEEF);

        // Continuous CPU plus host read: four CPU wins, one forced host turn
        host_op(0, 1'b1, 16'h0020, 16'hA5A5, rd, lat);
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 16'h0030;
        h_req[0] = 1'b1; h_we[0] = 1'b0; h_addr[0] = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cs_stall", o_stall[0], i == 4);
            chk("cs_ack", o_ack[0], i == 5);
            chk("cs_addr", o_addr[0], (i == 4) ? 16'h0020 : 16'h0030);
            if (i == 5) chk("cs_rdata", o_hrd[0], 16'hA5A5);
            next_cyc();
            if (i == 5) h_req[0] = 1'b0;
        end
        c_req[0] = 1'b0;

        // STARVE_MAX=0: host first, CPU store completes the next cycle
        c_req[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 16'h0044; c_wd[1] = 16'h7777;
        h_req[1] = 1'b1; h_we[1] = 1'b0; h_addr[1] = 16'h0044;
        @(negedge clk);
        chk("z_stall0", o_stall[1], 1'b1);
        chk("z_we0", o_we[1], 1'b0);
        next_cyc();
        @(negedge clk);
        chk("z_stall1", o_stall[1], 1'b0);
        chk("z_we1", o_we[1], 1'b1);
        chk("z_ack1", o_ack[1], 1'b1);
        chk("z_old", o_hrd[1], 16'h0000);
        next_cyc();
        c_req[1] = 1'b0; h_req[1] = 1'b0;
        host_op(1, 1'b0, 16'h0044, 16'h0, rd, lat);
        chk("z_data", rd, 16'h7777);

        // Held host request: accesses two cycles apart with a cooldown in between
        h_req[0] = 1'b1; h_we[0] = 1'b0; h_addr[0] = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_ack", o_ack[0], (i == 1) || (i == 3));
            chk("hold_addr", o_addr[0], (i == 0 || i == 2) ? 16'h0010 : 16'h0000);
            if (i == 3) chk("hold_data", o_hrd[0], 16'hBEEF);
            next_cyc();
        end
        h_req[0] = 1'b0;

        // CPU store right before a host read of the same word
        c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 16'h0040; c_wd[0] = 16'h1234;
        @(negedge clk);
        chk("st_we", o_we[0], 1'b1);
        next_cyc();
        c_req[0] = 1'b0; c_we[0] = 1'b0;
        host_op(0, 1'b0, 16'h0040, 16'h0, rd, lat);
        chk("st_fwd", rd, 16'h1234);

        // Randomized traffic on both instances, checked by the reference every cycle
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                seen_stall[k] = o_stall[k];
                seen_ack[k]   = o_ack[k];
            end
            next_cyc();
            for (int k = 0; k < 2; k++) begin
                if (!seen_stall[k]) begin
                    c_req[k]  = ($urandom_range(0, 3) != 0);
                    c_we[k]   = 1'($urandom_range(0, 1));
                    c_addr[k] = 16'($urandom_range(0, 63));
                    c_wd[k]   = 16'($urandom);
                end
                if (h_req[k]) begin
                    if (seen_ack[k]) begin
                        if ($urandom_range(0, 1) == 0) h_req[k] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        h_req[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    h_req[k]  = 1'b1;
                    h_we[k]   = 1'($urandom_range(0, 1));
                    h_addr[k] = 16'($urandom_range(0, 63));
                    h_wd[k]   = 16'($urandom);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            c_req[k] = 1'b0;
            h_req[k] = 1'b0;
        end
        repeat (3) next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
